// File: rtl/i2s_tx.sv
// Philips I2S transmitter: serializes 16-bit stereo samples onto BCLK/LRCK/DATA.
// Define I2S_TX_LEFT_JUSTIFIED_EN to select left-justified framing.
module i2s_tx #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             i2s_bclk,
  output logic             i2s_lrck,
  output logic             i2s_data,
  output logic             frame_stb
);

  localparam int SLOTS = 2 * WIDTH;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW    = $clog2(SLOTS);
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [DW-1:0]    div_cnt;
  logic [SW-1:0]    slot;
  logic [SW-1:0]    slot_nxt;
  logic [WIDTH-1:0] l_h;
  logic [WIDTH-1:0] r_h;
  logic [IW-1:0]    l_idx;
  logic [IW-1:0]    r_idx;
  logic             div_tc;
  logic             fall_evt;
  logic             data_nxt;
  logic             lrck_nxt;

  assign div_tc   = (div_cnt == DW'(CLK_DIV - 1));
  assign fall_evt = div_tc & i2s_bclk;
  assign slot_nxt = (slot == SW'(SLOTS - 1)) ? '0 : slot + 1'b1;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  // Slot 0 carries the left MSB, so it comes straight from the input being captured.
  always_comb begin
    l_idx    = IW'(WIDTH - 1 - int'(slot_nxt));
    r_idx    = IW'(2 * WIDTH - 1 - int'(slot_nxt));
    data_nxt = 1'b0;
    if (slot_nxt == '0)
      data_nxt = left[WIDTH-1];
    else if (int'(slot_nxt) < WIDTH)
      data_nxt = l_h[l_idx];
    else
      data_nxt = r_h[r_idx];
    lrck_nxt = (int'(slot_nxt) < WIDTH);
  end
`else
  logic r0;

  // One-bit delay: the right LSB spills into slot 0 of the following frame via r0.
  always_comb begin
    l_idx    = IW'(WIDTH - int'(slot_nxt));
    r_idx    = IW'(2 * WIDTH - int'(slot_nxt));
    data_nxt = 1'b0;
    if (slot_nxt == '0)
      data_nxt = r0;
    else if (int'(slot_nxt) <= WIDTH)
      data_nxt = l_h[l_idx];
    else
      data_nxt = r_h[r_idx];
    lrck_nxt = (int'(slot_nxt) >= WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r0 <= 1'b0;
    else if (fall_evt && slot_nxt == SW'(SLOTS - 1))
      r0 <= r_h[0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      slot      <= SW'(SLOTS - 1);
      l_h       <= '0;
      r_h       <= '0;
      i2s_lrck  <= 1'b0;
      i2s_data  <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      if (div_tc) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end
      // Data, LRCK and strobe move together with the BCLK falling toggle.
      if (fall_evt) begin
        slot     <= slot_nxt;
        i2s_data <= data_nxt;
        i2s_lrck <= lrck_nxt;
        if (slot_nxt == '0) begin
          l_h       <= left;
          r_h       <= right;
          frame_stb <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (CLK_DIV=2 and CLK_DIV=1) compared every cycle
// against a timing/bitstream model derived from cycle count since reset release.
module tb_i2s_tx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic         bclk0, lrck0, data0, stb0;
  logic         bclk1, lrck1, data1, stb1;

  int n_checks = 0;
  int n_errors = 0;
  int c = 0;                      // posedges since reset release
  logic [W-1:0] cap_l [2][128];
  logic [W-1:0] cap_r [2][128];

  always #5 clk = ~clk;

  i2s_tx #(.CLK_DIV(2), .WIDTH(W)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right),
    .i2s_bclk(bclk0), .i2s_lrck(lrck0), .i2s_data(data0), .frame_stb(stb0)
  );

  i2s_tx #(.CLK_DIV(1), .WIDTH(W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right),
    .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_data(data1), .frame_stb(stb1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at c=%0d: got %h expected %h", tag, c, got, exp);
    end
  endtask

  function automatic int cdiv_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Expected {bclk, lrck, data, stb} after c posedges, from the framing rules.
  function automatic logic [3:0] model(input int d, input int cc);
    int cd, k, n, f;
    logic b, lr, dt, st;
    cd = cdiv_of(d);
    b  = ((cc / cd) % 2) == 1;
    k  = cc / (2 * cd);
    lr = 1'b0; dt = 1'b0; st = 1'b0;
    if (k > 0) begin
      n  = (k - 1) % (2 * W);
      f  = (k - 1) / (2 * W);
      st = (cc == 2 * cd * k) && (n == 0);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      lr = (n < W);
      if (n < W) dt = cap_l[d][f][W-1-n];
      else       dt = cap_r[d][f][2*W-1-n];
`else
      lr = (n >= W);
      if (n == 0)      dt = (f == 0) ? 1'b0 : cap_r[d][f-1][0];
      else if (n <= W) dt = cap_l[d][f][W-n];
      else             dt = cap_r[d][f][2*W-n];
`endif
    end
    return {b, lr, dt, st};
  endfunction

  // Cycle counter and capture bookkeeping (bench records what it drove at slot-0 entries).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c = 0;
    end else begin
      c = c + 1;
      for (int d = 0; d < 2; d++) begin
        int cd, k;
        cd = cdiv_of(d);
        if (c % (2 * cd) == 0) begin
          k = c / (2 * cd);
          if ((k - 1) % (2 * W) == 0 && (k - 1) / (2 * W) < 128) begin
            cap_l[d][(k-1)/(2*W)] = left;
            cap_r[d][(k-1)/(2*W)] = right;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("dut0_pins{bclk,lrck,data,stb}", {28'd0, bclk0, lrck0, data0, stb0}, {28'd0, model(0, c)});
    check("dut1_pins{bclk,lrck,data,stb}", {28'd0, bclk1, lrck1, data1, stb1}, {28'd0, model(1, c)});
  end

  task automatic rand_inputs(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(7, 0) == 0) begin
        left  = W'($urandom);
        right = W'($urandom);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    left  = '0;
    right = '0;
    repeat (3) @(negedge clk);
    left  = 16'h8001;
    right = 16'h7FFE;
    rst_n = 1'b1;

    // Slot 5 of DUT0 frame 2 is entered at fall event k=70, i.e. c=280.
    while (c < 4 * (2 * 2 * W + 6)) @(negedge clk);
    left = 16'h1234;
    while (c < 4 * (4 * 2 * W + 1)) @(negedge clk);

    rand_inputs(768);

    // Land inside DUT0 slot 20, then reset asynchronously between edges.
    while ((c / 4) % (2 * W) != 21) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_dut0", {28'd0, bclk0, lrck0, data0, stb0}, 32'd0);
    check("rst_async_dut1", {28'd0, bclk1, lrck1, data1, stb1}, 32'd0);
    repeat (4) @(negedge clk);
    left  = 16'hA5A5;
    right = 16'h0F0F;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    rand_inputs(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
